// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: inter-stage pipeline register with valid/ready handshake.
// MODE=0 (SKID): 2-entry skid buffer, in_ready is registered from state only.
// MODE=1 (PASS): 1-entry register, in_ready = out_ready | ~out_valid.
// Empty stage presents a bubble: out_valid=0 and ctrl bits [CTRL_W-1:0] = 0.
// Ports:
//   clk, startin (async active-low reset)
//   flush                            - synchronous discard of held/incoming entries
//   in_valid/in_ready/in_data        - upstream handshake
//   out_valid/out_ready/out_data     - downstream handshake
//   occupancy                        - held entries (0..2)
//   drop_cnt                         - saturating count of flushed entries
module pipe_skid_stage #(
  parameter int unsigned DATA_W = 71,
  parameter int unsigned CTRL_W = 2,
  parameter int unsigned MODE   = 0,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              startin,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  drop_cnt
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  localparam int unsigned SUM_W = CNT_W + 2;
  localparam logic [DATA_W-1:0] KEEP_MASK = {{(DATA_W-CTRL_W){1'b1}}, {CTRL_W{1'b0}}};
  localparam logic [SUM_W-1:0]  CNT_MAX   = {2'b00, {CNT_W{1'b1}}};

  logic [1:0]        state, state_nxt;
  logic [DATA_W-1:0] main_q, main_nxt;
  logic [DATA_W-1:0] skid_q, skid_nxt;
  logic [CNT_W-1:0]  drop_nxt;
  logic              rdy_q, rdy_nxt;
  logic              in_fire_c, out_fire_c;
  logic [2:0]        drop_inc_c;
  logic [SUM_W-1:0]  drop_sum_c;

  // Outputs decoded straight from flops; state encoding equals occupancy.
  assign out_valid = (state != ST_EMPTY);
  assign out_data  = main_q;
  assign occupancy = state;

  // rdy_q keeps in_ready low through reset and tracks "not full" in SKID mode.
  generate
    if (MODE == 1) begin : g_pass
      assign in_ready = rdy_q & (out_ready | ~out_valid);
    end else begin : g_skid
      assign in_ready = rdy_q;
    end
  endgenerate

  assign in_fire_c  = in_valid & in_ready;
  assign out_fire_c = out_valid & out_ready;

  // Entries discarded by a flush: held plus incoming, minus one leaving downstream.
  assign drop_inc_c = 3'(state) + 3'(in_fire_c) - 3'(out_fire_c);
  assign drop_sum_c = SUM_W'(drop_cnt) + SUM_W'(drop_inc_c);

  // State register.
  always_ff @(posedge clk or negedge startin) begin
    if (!startin) begin
      state    <= ST_EMPTY;
      main_q   <= '0;
      skid_q   <= '0;
      drop_cnt <= '0;
      rdy_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      main_q   <= main_nxt;
      skid_q   <= skid_nxt;
      drop_cnt <= drop_nxt;
      rdy_q    <= rdy_nxt;
    end
  end

  // Next-state and datapath selection.
  always_comb begin
    state_nxt = state;
    main_nxt  = main_q;
    skid_nxt  = skid_q;
    drop_nxt  = drop_cnt;

    case (state)
      ST_EMPTY: begin
        if (in_fire_c) begin
          state_nxt = ST_ONE;
          main_nxt  = in_data;
        end
      end
      ST_ONE: begin
        if (in_fire_c && out_fire_c) begin
          main_nxt = in_data;
        end else if (in_fire_c) begin
          state_nxt = ST_TWO;
          skid_nxt  = in_data;
        end else if (out_fire_c) begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (out_fire_c) begin
          state_nxt = ST_ONE;
          main_nxt  = skid_q;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase

    if (flush) begin
      state_nxt = ST_EMPTY;
      main_nxt  = main_q;
      skid_nxt  = skid_q;
      drop_nxt  = (drop_sum_c > CNT_MAX) ? drop_cnt | {CNT_W{1'b1}} : CNT_W'(drop_sum_c);
    end

    // Bubble: ctrl bits cleared whenever the stage goes empty, payload bits kept.
    if (state_nxt == ST_EMPTY) begin
      main_nxt = main_nxt & KEEP_MASK;
    end

    rdy_nxt = (state_nxt != ST_TWO) || (MODE == 1);
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Testbench for pipe_skid_stage: table-driven SKID vectors plus hand-written
// sequences for reset, drop-count saturation, PASS mode and async reset.
module tb_pipe_skid_stage;

  localparam int unsigned DW = 71;
  localparam logic [DW-1:0] HI = 71'h40_0000_0000_0000_0000;

  logic clk = 1'b0;
  logic startin;

  // SKID instance, default widths
  logic          f0, iv0, ir0, ov0, or0;
  logic [DW-1:0] id0, od0;
  logic [1:0]    oc0;
  logic [15:0]   dc0;

  // SKID instance with 2-bit drop counter
  logic          fs, ivs, irs, ovs, ors;
  logic [7:0]    ids, ods;
  logic [1:0]    ocs;
  logic [1:0]    dcs;

  // PASS instance
  logic          fp, ivp, irp, ovp, orp;
  logic [7:0]    idp, odp;
  logic [1:0]    ocp;
  logic [15:0]   dcp;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_skid_stage #(.DATA_W(DW), .CTRL_W(2), .MODE(0), .CNT_W(16)) dut0 (
    .clk(clk), .startin(startin), .flush(f0), .in_valid(iv0), .in_ready(ir0),
    .in_data(id0), .out_valid(ov0), .out_ready(or0), .out_data(od0),
    .occupancy(oc0), .drop_cnt(dc0));

  pipe_skid_stage #(.DATA_W(8), .CTRL_W(2), .MODE(0), .CNT_W(2)) dut_sat (
    .clk(clk), .startin(startin), .flush(fs), .in_valid(ivs), .in_ready(irs),
    .in_data(ids), .out_valid(ovs), .out_ready(ors), .out_data(ods),
    .occupancy(ocs), .drop_cnt(dcs));

  pipe_skid_stage #(.DATA_W(8), .CTRL_W(2), .MODE(1), .CNT_W(16)) dut_pass (
    .clk(clk), .startin(startin), .flush(fp), .in_valid(ivp), .in_ready(irp),
    .in_data(idp), .out_valid(ovp), .out_ready(orp), .out_data(odp),
    .occupancy(ocp), .drop_cnt(dcp));

  typedef struct {
    logic          flush;
    logic          iv;
    logic [DW-1:0] d;
    logic          ordy;
    logic          ov;
    logic [DW-1:0] od;
    logic [1:0]    occ;
    logic          ir;
    logic [15:0]   drop;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic fl, input logic iv, input logic [DW-1:0] d,
                         input logic ordy, input logic ov, input logic [DW-1:0] od,
                         input logic [1:0] occ, input logic ir, input logic [15:0] drop);
    vec_t v;
    v.flush = fl; v.iv = iv; v.d = d; v.ordy = ordy;
    v.ov = ov; v.od = od; v.occ = occ; v.ir = ir; v.drop = drop;
    vq.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] sat_exp;

    // Expected state after each edge: {flush, in_valid, in_data, out_ready} -> outputs
    // Stream at full rate, 1-cycle latency
    add_vec(0, 1, 71'h11,      1, 1, 71'h11,      1, 1, 0);
    add_vec(0, 1, 71'h12,      1, 1, 71'h12,      1, 1, 0);
    add_vec(0, 1, 71'h13,      1, 1, 71'h13,      1, 1, 0);
    add_vec(0, 1, 71'h14,      1, 1, 71'h14,      1, 1, 0);
    add_vec(0, 1, 71'h15,      1, 1, 71'h15,      1, 1, 0);
    add_vec(0, 1, HI | 71'h16, 1, 1, HI | 71'h16, 1, 1, 0);
    add_vec(0, 0, 71'h0,       1, 0, HI | 71'h14, 0, 1, 0);
    // Stall: fill both entries, extra input ignored, then drain in order
    add_vec(0, 1, 71'h21,      0, 1, 71'h21,      1, 1, 0);
    add_vec(0, 1, 71'h22,      0, 1, 71'h21,      2, 0, 0);
    add_vec(0, 1, 71'h23,      0, 1, 71'h21,      2, 0, 0);
    add_vec(0, 0, 71'h0,       1, 1, 71'h22,      1, 1, 0);
    add_vec(0, 0, 71'h0,       1, 0, 71'h20,      0, 1, 0);
    // Flush from full (in_ready=0 so incoming is not taken): +2,
    // then flush an empty stage while an entry fires in: +1 -> total 3
    add_vec(0, 1, 71'h31,      0, 1, 71'h31,      1, 1, 0);
    add_vec(0, 1, 71'h32,      0, 1, 71'h31,      2, 0, 0);
    add_vec(1, 1, 71'h33,      0, 0, 71'h30,      0, 1, 2);
    add_vec(1, 1, 71'h34,      0, 0, 71'h30,      0, 1, 3);
    // Flush with in_fire and out_fire: held entry leaves downstream, only incoming dropped
    add_vec(0, 1, 71'h41,      0, 1, 71'h41,      1, 1, 3);
    add_vec(1, 1, 71'h42,      1, 0, 71'h40,      0, 1, 4);
    add_vec(0, 1, 71'h43,      1, 1, 71'h43,      1, 1, 4);
    add_vec(0, 0, 71'h0,       0, 1, 71'h43,      1, 1, 4);
    add_vec(0, 0, 71'h0,       1, 0, 71'h40,      0, 1, 4);

    startin = 1'b0;
    f0 = 0; iv0 = 1; id0 = 71'h55; or0 = 1;
    fs = 0; ivs = 0; ids = 8'h0; ors = 0;
    fp = 0; ivp = 0; idp = 8'h0; orp = 1;

    // Reset held for two cycles
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", ov0, 1'b0);
    chk("rst_out_data", od0, 71'h0);
    chk("rst_in_ready", ir0, 1'b0);
    chk("rst_drop_cnt", dc0, 16'h0);
    chk("rst_occupancy", oc0, 2'd0);
    chk("rst_pass_in_ready", irp, 1'b0);
    @(negedge clk);
    startin = 1'b1;
    iv0 = 0;
    #1;
    chk("release_in_ready_same_cycle", ir0, 1'b0);
    @(posedge clk);
    #1;
    chk("release_in_ready_next_cycle", ir0, 1'b1);
    @(negedge clk);

    for (int i = 0; i < vq.size(); i++) begin
      f0 = vq[i].flush; iv0 = vq[i].iv; id0 = vq[i].d; or0 = vq[i].ordy;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_out_valid", i), ov0, vq[i].ov);
      chk($sformatf("v%0d_out_data", i), od0, vq[i].od);
      chk($sformatf("v%0d_occupancy", i), oc0, vq[i].occ);
      chk($sformatf("v%0d_in_ready", i), ir0, vq[i].ir);
      chk($sformatf("v%0d_drop_cnt", i), dc0, vq[i].drop);
      @(negedge clk);
    end
    f0 = 0; iv0 = 0; or0 = 0;

    // Saturation: three flushes of two entries each on a 2-bit counter
    for (int k = 0; k < 3; k++) begin
      ivs = 1; ids = 8'(2 * k + 1); ors = 0;
      @(posedge clk); @(negedge clk);
      ids = 8'(2 * k + 2);
      @(posedge clk); @(negedge clk);
      chk($sformatf("sat%0d_full", k), ocs, 2'd2);
      ivs = 0; fs = 1;
      @(posedge clk);
      #1;
      sat_exp = (k == 0) ? 2'd2 : 2'd3;
      chk($sformatf("sat%0d_drop_cnt", k), dcs, sat_exp);
      chk($sformatf("sat%0d_empty", k), ocs, 2'd0);
      @(negedge clk);
      fs = 0;
    end

    // PASS mode: combinational in_ready, replace without bubble
    ivp = 1; idp = 8'hA5; orp = 0;
    @(posedge clk);
    #1;
    chk("pass_first_valid", ovp, 1'b1);
    chk("pass_first_data", odp, 8'hA5);
    chk("pass_first_occ", ocp, 2'd1);
    idp = 8'h5A;
    #1;
    chk("pass_full_stall_in_ready", irp, 1'b0);
    @(posedge clk);
    #1;
    chk("pass_stall_hold_data", odp, 8'hA5);
    @(negedge clk);
    orp = 1;
    #1;
    chk("pass_ready_in_ready", irp, 1'b1);
    @(posedge clk);
    #1;
    chk("pass_replace_valid", ovp, 1'b1);
    chk("pass_replace_data", odp, 8'h5A);
    chk("pass_replace_occ", ocp, 2'd1);
    @(negedge clk);
    idp = 8'h3F;
    @(posedge clk);
    #1;
    chk("pass_replace2_data", odp, 8'h3F);
    @(negedge clk);
    ivp = 0;
    @(posedge clk);
    #1;
    chk("pass_drain_valid", ovp, 1'b0);
    chk("pass_bubble_data", odp, 8'h3C);
    chk("pass_drop_cnt", dcp, 16'h0);
    @(negedge clk);

    // Async reset in the middle of a transfer
    iv0 = 1; id0 = 71'h77; or0 = 0;
    @(posedge clk);
    #1;
    chk("arst_pre_valid", ov0, 1'b1);
    #2;
    startin = 1'b0;
    #1;
    chk("arst_out_valid", ov0, 1'b0);
    chk("arst_out_data", od0, 71'h0);
    chk("arst_occupancy", oc0, 2'd0);
    chk("arst_drop_cnt", dc0, 16'h0);
    chk("arst_in_ready", ir0, 1'b0);
    @(negedge clk);
    iv0 = 0;
    startin = 1'b1;
    @(posedge clk);
    #1;
    chk("arst_release_empty", ov0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
